// File: rtl/lc3b_cache.sv
// lc3b_cache: direct-mapped, write-back, write-allocate cache that sits between
// the LC-3b CPU word port and a line-wide physical memory port.
module lc3b_cache #(
   parameter int NUM_LINES  = 8,
   parameter int LINE_BYTES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [1:0]              mem_byte_enable,
   input  logic [15:0]             mem_address,
   input  logic [15:0]             mem_wdata,
   output logic [15:0]             mem_rdata,
   output logic                    mem_resp,
   output logic                    pmem_read,
   output logic                    pmem_write,
   output logic [15:0]             pmem_address,
   output logic [8*LINE_BYTES-1:0] pmem_wdata,
   input  logic [8*LINE_BYTES-1:0] pmem_rdata,
   input  logic                    pmem_resp
);

   localparam int OFF  = $clog2(LINE_BYTES);
   localparam int IDX  = $clog2(NUM_LINES);
   localparam int TAGW = 16 - OFF - IDX;
   localparam int WB   = (OFF > 1) ? OFF - 1 : 1;

   typedef enum logic [1:0] {IDLE, RESPOND, WRITEBACK, FILL} state_t;

   state_t                  state;
   logic [NUM_LINES-1:0]    valid;
   logic [NUM_LINES-1:0]    dirty;
   logic [TAGW-1:0]         line_tag  [NUM_LINES];
   logic [8*LINE_BYTES-1:0] line_data [NUM_LINES];

   logic [IDX-1:0]  index;
   logic [TAGW-1:0] req_tag;
   logic [WB-1:0]   word_sel;
   logic            request;
   logic            hit;
   logic            fill_done;
   logic            write_hit;
   logic            unused_bits;

   assign index   = mem_address[OFF+IDX-1:OFF];
   assign req_tag = mem_address[15:OFF+IDX];
   assign unused_bits = mem_address[0];

   // With two-byte lines there is only one word, so the word select collapses to zero.
   generate
      if (OFF > 1) begin : g_word_sel
         assign word_sel = mem_address[OFF-1:1];
      end else begin : g_single_word
         assign word_sel = '0;
      end
   endgenerate

   assign request    = mem_read | mem_write;
   assign hit        = valid[index] && (line_tag[index] == req_tag);
   assign fill_done  = (state == FILL) && pmem_resp;
   assign write_hit  = (state == IDLE) && mem_write && hit;
   assign pmem_wdata = line_data[index];

   // Tag and data storage are never reset; only a completed fill or a write hit changes them.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_data[index] <= pmem_rdata;
         line_tag[index]  <= req_tag;
      end else if (write_hit) begin
         if (mem_byte_enable[0])
            line_data[index][{word_sel, 4'b0000} +: 8] <= mem_wdata[7:0];
         if (mem_byte_enable[1])
            line_data[index][{word_sel, 4'b1000} +: 8] <= mem_wdata[15:8];
      end
   end

   // Controller: hit/miss decision, line writeback and fill sequencing, registered handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem_resp     <= 1'b0;
         mem_rdata    <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         valid        <= '0;
         dirty        <= '0;
      end else begin
         mem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (request) begin
                  if (hit) begin
                     if (mem_write)
                        dirty[index] <= 1'b1;
                     else
                        mem_rdata <= line_data[index][{word_sel, 4'b0000} +: 16];
                     mem_resp <= 1'b1;
                     state    <= RESPOND;
                  end else if (valid[index] && dirty[index]) begin
                     pmem_write   <= 1'b1;
                     pmem_address <= {line_tag[index], index, {OFF{1'b0}}};
                     state        <= WRITEBACK;
                  end else begin
                     pmem_read    <= 1'b1;
                     pmem_address <= {req_tag, index, {OFF{1'b0}}};
                     state        <= FILL;
                  end
               end
            end
            RESPOND: begin
               state <= IDLE;
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  dirty[index] <= 1'b0;
                  pmem_write   <= 1'b0;
                  pmem_read    <= 1'b1;
                  pmem_address <= {req_tag, index, {OFF{1'b0}}};
                  state        <= FILL;
               end
            end
            FILL: begin
               if (pmem_resp) begin
                  valid[index] <= 1'b1;
                  dirty[index] <= 1'b0;
                  pmem_read    <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_cache.sv
// tb_lc3b_cache: directed test of lc3b_cache against a memory-level reference model.
module tb_lc3b_cache;

   logic         clk;
   logic         rst_n;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_address;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   lc3b_cache #(.NUM_LINES(8), .LINE_BYTES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Architectural memory as the CPU must see it, and the backing physical memory
   logic [15:0] arch [int];
   logic [15:0] phys [int];

   // Which line each cache slot should hold
   bit mvalid [8];
   bit mdirty [8];
   int mtag   [8];

   // Expectations published to the cycle-by-cycle compare process
   bit           armed;
   logic [15:0]  exp_wb_addr;
   logic [127:0] exp_wb_line;
   logic [15:0]  exp_fill_addr;
   bit           exp_is_read;
   logic [15:0]  exp_rdata;

   // Observations recorded by the request driver
   logic [15:0]  last_rdata;
   logic [15:0]  last_wb_addr;
   logic [127:0] last_wb_line;
   bit           saw_fill;
   bit           saw_wb;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pattern(input int a);
      return 16'((a & 16'hFFF0) + 16'h1000 + ((a >> 1) & 7));
   endfunction

   function automatic logic [15:0] archWord(input int a);
      return arch.exists(a) ? arch[a] : pattern(a);
   endfunction

   function automatic logic [15:0] physWord(input int a);
      return phys.exists(a) ? phys[a] : pattern(a);
   endfunction

   function automatic logic [127:0] archLine(input int base);
      logic [127:0] l;
      for (int k = 0; k < 8; k++) l[k*16 +: 16] = archWord(base + 2*k);
      return l;
   endfunction

   function automatic logic [127:0] physLine(input int base);
      logic [127:0] l;
      for (int k = 0; k < 8; k++) l[k*16 +: 16] = physWord(base + 2*k);
      return l;
   endfunction

   // Compare process: memory-side traffic must always target the line the model predicts
   always @(negedge clk) begin
      if (rst_n && armed) begin
         if (pmem_read || pmem_write)
            checkOutput("pmem_exclusive", {127'd0, pmem_read && pmem_write}, 128'd0);
         if (pmem_write) begin
            checkOutput("wb_address", {112'd0, pmem_address}, {112'd0, exp_wb_addr});
            checkOutput("wb_data", pmem_wdata, exp_wb_line);
         end
         if (pmem_read)
            checkOutput("fill_address", {112'd0, pmem_address}, {112'd0, exp_fill_addr});
         if (mem_resp && exp_is_read)
            checkOutput("rdata", {112'd0, mem_rdata}, {112'd0, exp_rdata});
      end
   end

   // One CPU request with a physical memory that answers after dly cycles
   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be, input int dly);
      int idx, tag, waddr, resps, resp_cycle, first_pmem, fill_c, pwait, post;
      bit exp_hit, exp_wb;
      idx   = (int'(addr) >> 4) & 7;
      tag   = int'(addr) >> 7;
      waddr = int'(addr) & 16'hFFFE;
      exp_hit = mvalid[idx] && (mtag[idx] == tag);
      exp_wb  = !exp_hit && mvalid[idx] && mdirty[idx];
      exp_wb_addr   = 16'((mtag[idx] << 7) | (idx << 4));
      exp_wb_line   = archLine((mtag[idx] << 7) | (idx << 4));
      exp_fill_addr = addr & 16'hFFF0;
      exp_is_read   = rd && !wr;
      exp_rdata     = archWord(waddr);
      saw_fill = 0; saw_wb = 0;
      resps = 0; resp_cycle = -1; first_pmem = -1; fill_c = -1; pwait = 0; post = 0;
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
      for (int c = 1; c <= 300 && post < 4; c++) begin
         @(posedge clk); #1;
         if (pmem_resp) pmem_resp = 1'b0;
         if (pmem_read || pmem_write) begin
            if (first_pmem < 0) first_pmem = c;
            if (pwait == dly) begin
               if (pmem_write) begin
                  for (int k = 0; k < 8; k++) phys[int'(pmem_address) + 2*k] = pmem_wdata[k*16 +: 16];
                  last_wb_addr = pmem_address;
                  last_wb_line = pmem_wdata;
                  saw_wb = 1;
               end else begin
                  pmem_rdata = physLine(int'(pmem_address));
                  saw_fill = 1;
                  fill_c = c;
               end
               pmem_resp = 1'b1;
               pwait = 0;
            end else begin
               pwait++;
            end
         end
         if (mem_resp) begin
            resps++;
            if (resp_cycle < 0) begin
               resp_cycle = c;
               last_rdata = mem_rdata;
            end
         end
         if (resps > 0) begin
            post++;
            if (post == 2) begin
               mem_read = 1'b0; mem_write = 1'b0;
            end
         end
      end
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      checkOutput("resp_count", 128'(resps), 128'd1);
      if (exp_hit) begin
         checkOutput("hit_latency", 128'(resp_cycle), 128'd1);
         checkOutput("hit_no_pmem", {127'd0, saw_fill || saw_wb}, 128'd0);
      end else begin
         checkOutput("miss_fill", {127'd0, saw_fill}, 128'd1);
         checkOutput("miss_wb", {127'd0, saw_wb}, {127'd0, exp_wb});
         checkOutput("pmem_start", 128'(first_pmem), 128'd1);
         checkOutput("miss_latency", 128'(resp_cycle), 128'(fill_c + 2));
         mvalid[idx] = 1; mtag[idx] = tag; mdirty[idx] = 0;
      end
      if (wr) begin
         logic [15:0] w;
         w = archWord(waddr);
         if (be[0]) w[7:0]  = wdata[7:0];
         if (be[1]) w[15:8] = wdata[15:8];
         arch[waddr] = w;
         mdirty[idx] = 1;
      end
   endtask

   initial begin
      checks = 0; failures = 0; armed = 0;
      rst_n = 1'b0; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
      mem_address = 0; mem_wdata = 0; pmem_rdata = '0; pmem_resp = 0;
      for (int i = 0; i < 8; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = 0; end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_mem_resp", {127'd0, mem_resp}, 128'd0);
      checkOutput("reset_pmem_read", {127'd0, pmem_read}, 128'd0);
      checkOutput("reset_pmem_write", {127'd0, pmem_write}, 128'd0);
      checkOutput("reset_mem_rdata", {112'd0, mem_rdata}, 128'd0);
      checkOutput("reset_pmem_address", {112'd0, pmem_address}, 128'd0);
      @(negedge clk) rst_n = 1'b1;
      armed = 1;

      applyStimulus(1, 0, 16'h0010, 16'h0000, 2'b00, 3);
      checkOutput("lit_read_0010", {112'd0, last_rdata}, {112'd0, 16'h1010});
      applyStimulus(1, 0, 16'h0016, 16'h0000, 2'b00, 0);
      checkOutput("lit_read_0016", {112'd0, last_rdata}, {112'd0, 16'h1013});
      applyStimulus(0, 1, 16'h0012, 16'hABCD, 2'b01, 0);
      applyStimulus(1, 0, 16'h0012, 16'h0000, 2'b00, 0);
      checkOutput("lit_read_0012", {112'd0, last_rdata}, {112'd0, 16'h10CD});
      applyStimulus(1, 0, 16'h0090, 16'h0000, 2'b00, 2);
      checkOutput("lit_wb_addr_0010", {112'd0, last_wb_addr}, {112'd0, 16'h0010});
      checkOutput("lit_wb_word1", {112'd0, last_wb_line[31:16]}, {112'd0, 16'h10CD});
      checkOutput("lit_read_0090", {112'd0, last_rdata}, {112'd0, 16'h1090});
      applyStimulus(0, 1, 16'h0100, 16'h5555, 2'b11, 1);
      checkOutput("lit_wmiss_no_wb", {127'd0, saw_wb}, 128'd0);
      applyStimulus(1, 0, 16'h0100, 16'h0000, 2'b00, 0);
      checkOutput("lit_read_0100", {112'd0, last_rdata}, {112'd0, 16'h5555});
      applyStimulus(1, 0, 16'h0000, 16'h0000, 2'b00, 0);
      checkOutput("lit_wb_addr_0100", {112'd0, last_wb_addr}, {112'd0, 16'h0100});
      checkOutput("lit_wb_word0", {112'd0, last_wb_line[15:0]}, {112'd0, 16'h5555});
      applyStimulus(1, 1, 16'h0020, 16'h1234, 2'b10, 0);
      applyStimulus(1, 0, 16'h0020, 16'h0000, 2'b00, 0);
      checkOutput("lit_rw_as_write", {112'd0, last_rdata}, {112'd0, 16'h1220});
      applyStimulus(1, 0, 16'h00A0, 16'h0000, 2'b00, 7);
      applyStimulus(0, 1, 16'h0030, 16'hFFFF, 2'b00, 0);
      applyStimulus(1, 0, 16'h0030, 16'h0000, 2'b00, 0);
      checkOutput("lit_be00_unchanged", {112'd0, last_rdata}, {112'd0, 16'h1030});
      applyStimulus(1, 0, 16'h00B0, 16'h0000, 2'b00, 1);
      checkOutput("lit_be00_dirty_wb", {127'd0, saw_wb}, 128'd1);

      // Reset in the middle of a fill
      exp_fill_addr = 16'h0040; exp_is_read = 1'b1; exp_rdata = archWord(16'h0040);
      @(negedge clk);
      mem_read = 1'b1; mem_address = 16'h0040;
      begin
         int n;
         n = 0;
         do begin
            @(posedge clk); #1; n++;
         end while (!pmem_read && n < 20);
         checkOutput("midfill_pmem_read_seen", {127'd0, pmem_read}, 128'd1);
      end
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midfill_pmem_read_drop", {127'd0, pmem_read}, 128'd0);
      checkOutput("midfill_mem_resp", {127'd0, mem_resp}, 128'd0);
      mem_read = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
      arch = phys;
      applyStimulus(1, 0, 16'h0010, 16'h0000, 2'b00, 2);
      checkOutput("lit_post_reset_miss", {127'd0, saw_fill}, 128'd1);
      applyStimulus(1, 0, 16'h0012, 16'h0000, 2'b00, 0);
      checkOutput("lit_post_reset_0012", {112'd0, last_rdata}, {112'd0, 16'h10CD});

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lc3b_cache.md
# lc3b_cache

Parametrised direct-mapped, write-back, write-allocate cache between the LC-3b multicycle CPU memory port and line-wide physical memory. CPU side uses the existing word-wide request/response handshake (read/write held until a one-cycle response); memory side moves whole lines. Line count and line size are parameters, so the same block serves instruction/data splits and later pipelined cores.

## Interface
- NUM_LINES, 8, number of lines; power of 2, ≥2
- LINE_BYTES, 16, bytes per line; power of 2, 2..32
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  byte lanes for writes ([0]=low byte)
- mem_address  in  16  CPU byte address
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  read data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  16  line-aligned address (low log2(LINE_BYTES) bits 0)
- pmem_wdata  out  8*LINE_BYTES  writeback line
- pmem_rdata  in  8*LINE_BYTES  fill line, sampled when pmem_resp=1
- pmem_resp  in  1  physical memory completion pulse

## Operation
- Address split: OFF=log2(LINE_BYTES), IDX=log2(NUM_LINES); word select = addr[OFF-1:1], index = addr[OFF+IDX-1:OFF], tag = addr[15:OFF+IDX]. addr[0] ignored.
- Per line: valid, dirty, tag, data. Reset clears valid and dirty only; tag/data unreset.
- States: IDLE, RESPOND, WRITEBACK, FILL.
- IDLE, no request: stay. Request with valid & tag match (hit): read latches word into mem_rdata register; write merges mem_wdata into selected word per byte_enable and sets dirty; go RESPOND.
- IDLE, miss, line clean or invalid: go FILL. Miss, valid & dirty: go WRITEBACK.
- RESPOND: mem_resp=1 for exactly this cycle; go IDLE.
- WRITEBACK: pmem_write=1, pmem_address={old tag, index, 0}, pmem_wdata=line data; on pmem_resp clear dirty, go FILL.
- FILL: pmem_read=1, pmem_address={req tag, index, 0}; on pmem_resp write pmem_rdata into line, set valid, clear dirty, write tag; go IDLE (request now hits).
- mem_read and mem_write both high: treated as write.
- Write miss allocates (fill then merge on the following hit). byte_enable=2'b00 write: completes as hit, data unchanged, dirty set.
- pmem_read and pmem_write never high together.

## Timing
- Reset (async assert): state IDLE, mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0; all lines invalid and clean. Applies mid-fill/mid-writeback: requests drop immediately, partially handled line stays invalid/unchanged.
- Hit latency: request sampled at edge N, mem_resp high in cycle N+1 (one cycle after first sampling), low at N+2.
- Clean miss: edge N → FILL; pmem_read high from cycle N+1 until edge with pmem_resp; then IDLE one cycle, RESPOND next → mem_resp 2 cycles after pmem_resp edge.
- Dirty miss adds WRITEBACK phase ahead of FILL; FILL begins the cycle after pmem_resp for the writeback.
- pmem_resp with zero wait (high in first cycle of request) accepted.
- CPU deasserts request in the cycle after mem_resp; IDLE does not re-sample during RESPOND, so no double response.
- pmem_resp outside WRITEBACK/FILL ignored.

## Test plan
(NUM_LINES=8, LINE_BYTES=16; fill line for address A has word k = A+0x1000+k unless stated)
- Reset, read 0x0010 → pmem_read at 0x0010, pmem_resp after 3 cycles, mem_resp once with mem_rdata=0x1010; then read 0x0016 → mem_resp next cycle, mem_rdata=0x1013, no pmem activity.
- Write 0x0012, wdata 0xABCD, be=2'b01 (hit) → mem_resp next cycle; read 0x0012 returns 0x10CD.
- Then read 0x0090 (index 1, new tag) → pmem_write at 0x0010 with word1=0x10CD, then pmem_read at 0x0090, mem_rdata=0x1090.
- Write miss 0x0100, wdata 0x5555, be=2'b11 → clean fill at 0x0100, mem_resp once, subsequent read 0x0100 = 0x5555, later eviction writes it back.
- rst_n low while pmem_read high → pmem_read 0 same cycle; after release, read 0x0010 misses again.
- pmem_resp delays 0 and 7 cycles, and read+write both high → exactly one mem_resp per request, write semantics applied.
